stack_pusher: RTL
=================

// Module: stack_pusher
//
// PURPOSE
//  Write-side memory sequencer for the 6502 core: pushes 1-3 bytes onto the
//  hardware stack (JSR: PCH,PCL; BRK/IRQ/NMI: PCH,PCL,P; PHA/PHP: 1 byte).
//  Issues one bus write per cycle at {STACK_PAGE,SP} with post-decrement of SP.
//  Sits beside the fetcher on the address/data bus; the control unit starts it
//  and waits for done before resuming fetch.
//
// PARAMETERS
//  STACK_PAGE  8'h01  high address byte of the stack page
//  MAX_BYTES   3      largest push sequence supported (count field sized for it)
//
// PORTS
//  clk         in   1   single system clock (phi1 domain), rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  start       in   1   request a push sequence; sampled only in IDLE
//  count       in   2   bytes to push, 0..3 (0 = no write, done only)
//  byte0       in   8   first byte pushed (e.g. PCH)
//  byte1       in   8   second byte pushed (e.g. PCL)
//  byte2       in   8   third byte pushed (e.g. P)
//  sp_in       in   8   current stack pointer, sampled with start
//  addr        out  16  bus address, {STACK_PAGE, sp_cur} while writing
//  data_out    out  8   bus write data
//  we_mem      out  1   memory write strobe, one cycle per byte
//  sp_out      out  8   updated stack pointer
//  we_sp       out  1   one-cycle strobe: write sp_out into SP register
//  busy        out  1   high from cycle after accepted start until done cycle
//  done        out  1   one-cycle completion pulse
//
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; addr=16'h0000, data_out=8'h00,
//    we_mem=0, sp_out=8'hFF, we_sp=0, busy=0, done=0. Partial sequence is
//    abandoned; no further writes, SP register not updated.
//  - States: IDLE, WRITE, DONE.
//  - IDLE: start=1 latches count, byte0..2, sp_in; count!=0 -> WRITE,
//    count==0 -> DONE. start=0 -> stay.
//  - WRITE (one cycle per byte, idx=0..count-1): we_mem=1,
//    addr={STACK_PAGE,sp_cur}, data_out=byte[idx]; at clock edge
//    sp_cur<=sp_cur-1 (8-bit, wraps 8'h00->8'hFF, page never changes),
//    idx<=idx+1; after last byte -> DONE.
//  - DONE (one cycle): done=1, we_sp=1, sp_out=sp_latched-count (mod 256);
//    we_mem=0; -> IDLE. count==0 gives sp_out=sp_in.
//  - Latency: start at cycle 0 -> writes cycles 1..N -> done cycle N+1.
//  - busy=1 in WRITE and DONE; start while busy is ignored (not queued).
//  - start may be asserted in the cycle after done; accepted normally.
//  - Outputs registered; addr/data_out hold last value when we_mem=0.
//
// STRUCTURE
//  - pkg.v: STACK_PAGE default, push state encodings (PUSH_IDLE/WRITE/DONE).
//  - Single module, no sub-modules; byte select is a 3:1 mux on idx.
//
// TESTING
//  1 JSR: sp_in=FF,count=2,b0=C0,b1=12 -> writes 01FF<=C0 (c1), 01FE<=12
//    (c2); c3 done=1,we_sp=1,sp_out=FD.
//  2 BRK: sp_in=FD,count=3,b0=80,b1=05,b2=34 -> 01FD<=80,01FC<=05,01FB<=34;
//    sp_out=FA; exactly 3 we_mem cycles.
//  3 Wrap: sp_in=01,count=3 -> addrs 0101,0100,01FF; sp_out=FE.
//  4 count=0, sp_in=42 -> no we_mem; done next cycle, sp_out=42.
//  5 start held high during busy -> single sequence, done once; re-start
//    in cycle after done -> second sequence accepted.
//  6 reset_n low after first byte of 3-byte push -> we_mem=0, busy=0
//    immediately; no we_sp/done; idle after release.

Source files
------------

// File: rtl/stack_pusher_pkg.sv
// Shared definitions for the stack push sequencer.
//  - STACK_PAGE_DEF : default high address byte of the 6502 stack page
//  - MAX_BYTES_DEF  : longest push sequence (JSR/BRK/IRQ/NMI upper bound)
//  - push_state_e   : sequencer state encoding
package stack_pusher_pkg;

  localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;
  localparam int unsigned MAX_BYTES_DEF  = 3;

  typedef enum logic [1:0] {
    PushIdle  = 2'd0,
    PushWrite = 2'd1,
    PushDone  = 2'd2
  } push_state_e;

endpackage

// File: rtl/stack_pusher.sv
// Write-side stack sequencer for the 6502 core. Pushes 0..3 latched bytes, one
// bus write per cycle at {STACK_PAGE, sp}, post-decrementing sp, then pulses
// done/we_sp with the final stack pointer.
//
// Ports:
//  clk, reset_n          clock (rising edge), async active-low reset
//  start, count          request and byte count, sampled only in idle
//  byte0..byte2          bytes pushed in order
//  sp_in                 stack pointer, sampled with start
//  addr, data_out        bus address/data, hold last value when idle
//  we_mem                one-cycle write strobe per byte
//  sp_out, we_sp         new stack pointer and its load strobe
//  busy, done            sequence in flight / one-cycle completion pulse
module stack_pusher
  import stack_pusher_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEF,
  parameter int unsigned MAX_BYTES  = MAX_BYTES_DEF,
  localparam int unsigned CntW      = $clog2(MAX_BYTES + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [CntW-1:0] count,
  input  logic [7:0]      byte0,
  input  logic [7:0]      byte1,
  input  logic [7:0]      byte2,
  input  logic [7:0]      sp_in,
  output logic [15:0]     addr,
  output logic [7:0]      data_out,
  output logic            we_mem,
  output logic [7:0]      sp_out,
  output logic            we_sp,
  output logic            busy,
  output logic            done
);

  push_state_e     state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] idx_q, idx_d;      // bytes already issued to the bus
  logic [7:0]      b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [7:0]      sp_cur_q, sp_cur_d;  // address of the next write
  logic [7:0]      sp_lat_q, sp_lat_d;  // sp at start, for the final sp_out

  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        we_mem_q, we_mem_d;
  logic [7:0]  sp_out_q, sp_out_d;
  logic        we_sp_q, we_sp_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  byte_sel;

  // Byte select on the index of the next byte to be written.
  always_comb begin
    byte_sel = b0_q;
    case (idx_q)
      2'd1:    byte_sel = b1_q;
      2'd2:    byte_sel = b2_q;
      default: byte_sel = b0_q;
    endcase
  end

  // Outputs are registered: next-cycle outputs are decoded here from the
  // state being entered, so they line up with state_q in the following cycle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    sp_cur_d = sp_cur_q;
    sp_lat_d = sp_lat_q;
    addr_d   = addr_q;
    data_d   = data_q;
    sp_out_d = sp_out_q;
    we_mem_d = 1'b0;
    we_sp_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      PushIdle: begin
        if (start) begin
          count_d  = count;
          b0_d     = byte0;
          b1_d     = byte1;
          b2_d     = byte2;
          sp_lat_d = sp_in;
          busy_d   = 1'b1;
          if (count != '0) begin
            state_d  = PushWrite;
            we_mem_d = 1'b1;
            addr_d   = {STACK_PAGE, sp_in};
            data_d   = byte0;
            sp_cur_d = sp_in - 8'd1;
            idx_d    = 2'd1;
          end else begin
            state_d  = PushDone;
            done_d   = 1'b1;
            we_sp_d  = 1'b1;
            sp_out_d = sp_in;
          end
        end
      end

      PushWrite: begin
        busy_d = 1'b1;
        if (idx_q == count_q) begin
          state_d  = PushDone;
          done_d   = 1'b1;
          we_sp_d  = 1'b1;
          sp_out_d = sp_lat_q - 8'(count_q);
        end else begin
          we_mem_d = 1'b1;
          addr_d   = {STACK_PAGE, sp_cur_q};
          data_d   = byte_sel;
          sp_cur_d = sp_cur_q - 8'd1;
          idx_d    = idx_q + 2'd1;
        end
      end

      PushDone: begin
        // start here is dropped, not queued.
        state_d = PushIdle;
      end

      default: state_d = PushIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= PushIdle;
      count_q  <= '0;
      idx_q    <= '0;
      b0_q     <= 8'h00;
      b1_q     <= 8'h00;
      b2_q     <= 8'h00;
      sp_cur_q <= 8'hFF;
      sp_lat_q <= 8'hFF;
      addr_q   <= 16'h0000;
      data_q   <= 8'h00;
      we_mem_q <= 1'b0;
      sp_out_q <= 8'hFF;
      we_sp_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      sp_cur_q <= sp_cur_d;
      sp_lat_q <= sp_lat_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_mem_q <= we_mem_d;
      sp_out_q <= sp_out_d;
      we_sp_q  <= we_sp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign addr     = addr_q;
  assign data_out = data_q;
  assign we_mem   = we_mem_q;
  assign sp_out   = sp_out_q;
  assign we_sp    = we_sp_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
